// File: rtl/accumulator_mc.sv
// Multi-channel unsigned accumulator: one shared add/sub unit, per-channel state,
// sticky over/underflow flags, optional saturation, registered single-cycle result.
module accumulator_mc #(
   parameter int WIDTH    = 8,
   parameter int DWIDTH   = 4,
   parameter int CH_W     = 2,
   parameter int SATURATE = 0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en,
   input  logic [CH_W-1:0]        ch,
   input  logic                   sub,
   input  logic                   load,
   input  logic                   clr,
   input  logic [DWIDTH-1:0]      d,
   output logic [WIDTH-1:0]       q,
   output logic [CH_W-1:0]        q_ch,
   output logic                   q_vld,
   output logic [(2**CH_W)-1:0]   ovf
);

   localparam int CHANNELS = 2**CH_W;

   logic [WIDTH-1:0]    acc_reg [CHANNELS];
   logic [WIDTH-1:0]    cur_acc;
   logic [WIDTH:0]      d_ext;
   logic [WIDTH:0]      wide;
   logic [WIDTH-1:0]    acc_next;
   logic                ovf_bit_next;
   logic                op;
   logic [CHANNELS-1:0] wr_sel;

   assign op      = en | load | clr;
   assign cur_acc = acc_reg[ch];
   assign d_ext   = {{(WIDTH+1-DWIDTH){1'b0}}, d};

   // The extra top bit is the carry for an add and the borrow for a subtract.
   assign wide = sub ? ({1'b0, cur_acc} - d_ext) : ({1'b0, cur_acc} + d_ext);

   always_comb begin
      acc_next     = cur_acc;
      ovf_bit_next = ovf[ch];
      if (clr) begin
         acc_next     = '0;
         ovf_bit_next = 1'b0;
      end else if (load) begin
         acc_next     = d_ext[WIDTH-1:0];
         ovf_bit_next = 1'b0;
      end else if (en) begin
         acc_next = wide[WIDTH-1:0];
         if (wide[WIDTH]) begin
            ovf_bit_next = 1'b1;
            if (SATURATE != 0)
               acc_next = sub ? '0 : '1;
         end
      end
   end

   generate
      for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_sel
         assign wr_sel[gi] = op && (ch == CH_W'(gi));
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < CHANNELS; i++)
            acc_reg[i] <= '0;
         ovf   <= '0;
         q     <= '0;
         q_ch  <= '0;
         q_vld <= 1'b0;
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            if (wr_sel[i]) begin
               acc_reg[i] <= acc_next;
               ovf[i]     <= ovf_bit_next;
            end
         end
         q_vld <= op;
         if (op) begin
            q    <= acc_next;
            q_ch <= ch;
         end
      end
   end

endmodule

// File: tb/tb_accumulator_mc.sv
// Self-checking bench: a wrapping and a saturating instance share stimulus and
// are compared against an integer-arithmetic reference model.
module tb_accumulator_mc;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b0, sub = 1'b0, load = 1'b0, clr = 1'b0;
   logic [1:0] ch = '0;
   logic [3:0] d = '0;

   logic [7:0] q_o   [2];
   logic [1:0] qch_o [2];
   logic       qv_o  [2];
   logic [3:0] ovf_o [2];

   int m_acc [2][4];
   bit m_ovf [2][4];
   int m_q   [2];
   int m_qch [2];
   bit m_qv  [2];

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   accumulator_mc #(.WIDTH(8), .DWIDTH(4), .CH_W(2), .SATURATE(0)) u_wrap (
      .clk(clk), .rst(rst), .en(en), .ch(ch), .sub(sub), .load(load), .clr(clr), .d(d),
      .q(q_o[0]), .q_ch(qch_o[0]), .q_vld(qv_o[0]), .ovf(ovf_o[0])
   );

   accumulator_mc #(.WIDTH(8), .DWIDTH(4), .CH_W(2), .SATURATE(1)) u_sat (
      .clk(clk), .rst(rst), .en(en), .ch(ch), .sub(sub), .load(load), .clr(clr), .d(d),
      .q(q_o[1]), .q_ch(qch_o[1]), .q_vld(qv_o[1]), .ovf(ovf_o[1])
   );

   function automatic logic [3:0] model_ovf(input int s);
      logic [3:0] v;
      for (int c = 0; c < 4; c++) v[c] = m_ovf[s][c];
      return v;
   endfunction

   // Drive one cycle of inputs, then advance the reference model for both variants.
   task automatic step(input bit r, input bit e, input bit sb, input bit ld, input bit cl,
                       input int c, input int dd);
      @(negedge clk);
      rst = r; en = e; sub = sb; load = ld; clr = cl; ch = 2'(c); d = 4'(dd);
      @(posedge clk);
      #1;
      for (int s = 0; s < 2; s++) begin
         if (r) begin
            for (int k = 0; k < 4; k++) begin m_acc[s][k] = 0; m_ovf[s][k] = 0; end
            m_q[s] = 0; m_qch[s] = 0; m_qv[s] = 0;
         end else if (cl || ld || e) begin
            if (cl) begin
               m_acc[s][c] = 0; m_ovf[s][c] = 0;
            end else if (ld) begin
               m_acc[s][c] = dd; m_ovf[s][c] = 0;
            end else if (!sb) begin
               int sum = m_acc[s][c] + dd;
               if (sum > 255) begin
                  m_ovf[s][c] = 1;
                  sum = (s == 1) ? 255 : sum - 256;
               end
               m_acc[s][c] = sum;
            end else begin
               int diff = m_acc[s][c] - dd;
               if (diff < 0) begin
                  m_ovf[s][c] = 1;
                  diff = (s == 1) ? 0 : diff + 256;
               end
               m_acc[s][c] = diff;
            end
            m_q[s] = m_acc[s][c]; m_qch[s] = c; m_qv[s] = 1;
         end else begin
            m_qv[s] = 0;
         end
      end
   endtask

   task automatic test_reset();
      step(1, 0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0);
      for (int s = 0; s < 2; s++) begin
         checks++;
         if (q_o[s] !== 8'd0 || qv_o[s] !== 1'b0 || ovf_o[s] !== 4'b0000 || qch_o[s] !== 2'd0) begin
            errors++;
            $display("FAIL reset_idle inst%0d: q=%0d vld=%0b ovf=%b q_ch=%0d, required q=0 vld=0 ovf=0000 q_ch=0",
                     s, q_o[s], qv_o[s], ovf_o[s], qch_o[s]);
         end
      end
      for (int c = 0; c < 4; c++) begin
         step(0, 1, 0, 0, 0, c, 0);
         for (int s = 0; s < 2; s++) begin
            checks++;
            if (q_o[s] !== 8'd0 || qv_o[s] !== 1'b1 || qch_o[s] !== 2'(c)) begin
               errors++;
               $display("FAIL reset_read ch%0d inst%0d: q=%0d vld=%0b q_ch=%0d, required q=0 vld=1 q_ch=%0d",
                        c, s, q_o[s], qv_o[s], qch_o[s], c);
            end
         end
      end
      $display("test_reset done");
   endtask

   task automatic test_independent();
      int exp_q [3] = '{5, 3, 12};
      int exp_c [3] = '{0, 1, 0};
      int add_d [3] = '{5, 3, 7};
      for (int i = 0; i < 3; i++) begin
         step(0, 1, 0, 0, 0, exp_c[i], add_d[i]);
         for (int s = 0; s < 2; s++) begin
            checks++;
            if (q_o[s] !== 8'(exp_q[i]) || qch_o[s] !== 2'(exp_c[i]) || qv_o[s] !== 1'b1) begin
               errors++;
               $display("FAIL independent op%0d inst%0d: q=%0d q_ch=%0d vld=%0b, required q=%0d q_ch=%0d vld=1",
                        i, s, q_o[s], qch_o[s], qv_o[s], exp_q[i], exp_c[i]);
            end
         end
      end
      $display("test_independent done");
   endtask

   task automatic test_wrap();
      step(0, 0, 0, 1, 0, 2, 15);
      for (int i = 0; i < 16; i++) step(0, 1, 0, 0, 0, 2, 15);
      for (int s = 0; s < 2; s++) begin
         checks++;
         if (q_o[s] !== 8'd255 || ovf_o[s][2] !== 1'b0) begin
            errors++;
            $display("FAIL wrap_top inst%0d: q=%0d ovf2=%0b, required q=255 ovf2=0", s, q_o[s], ovf_o[s][2]);
         end
      end
      step(0, 1, 0, 0, 0, 2, 1);
      for (int s = 0; s < 2; s++) begin
         logic [7:0] want = (s == 1) ? 8'd255 : 8'd0;
         checks++;
         if (q_o[s] !== want || ovf_o[s][2] !== 1'b1) begin
            errors++;
            $display("FAIL wrap_over inst%0d: q=%0d ovf2=%0b, required q=%0d ovf2=1", s, q_o[s], ovf_o[s][2], want);
         end
      end
      $display("test_wrap done");
   endtask

   task automatic test_underflow();
      step(0, 0, 0, 1, 0, 3, 2);
      step(0, 1, 1, 0, 0, 3, 3);
      for (int s = 0; s < 2; s++) begin
         logic [7:0] want = (s == 1) ? 8'd0 : 8'd255;
         checks++;
         if (q_o[s] !== want || ovf_o[s][3] !== 1'b1) begin
            errors++;
            $display("FAIL underflow inst%0d: q=%0d ovf3=%0b, required q=%0d ovf3=1", s, q_o[s], ovf_o[s][3], want);
         end
      end
      step(0, 1, 0, 0, 0, 3, 1);
      for (int s = 0; s < 2; s++) begin
         logic [7:0] want = (s == 1) ? 8'd1 : 8'd0;
         checks++;
         if (q_o[s] !== want || ovf_o[s][3] !== 1'b1) begin
            errors++;
            $display("FAIL sticky inst%0d: q=%0d ovf3=%0b, required q=%0d ovf3=1", s, q_o[s], ovf_o[s][3], want);
         end
      end
      step(0, 0, 0, 0, 1, 3, 0);
      for (int s = 0; s < 2; s++) begin
         checks++;
         if (q_o[s] !== 8'd0 || ovf_o[s][3] !== 1'b0) begin
            errors++;
            $display("FAIL clr_ovf inst%0d: q=%0d ovf3=%0b, required q=0 ovf3=0", s, q_o[s], ovf_o[s][3]);
         end
      end
      $display("test_underflow done");
   endtask

   task automatic test_priority();
      step(0, 0, 0, 1, 0, 1, 9);
      step(0, 1, 0, 1, 1, 1, 5);
      for (int s = 0; s < 2; s++) begin
         checks++;
         if (q_o[s] !== 8'd0) begin
            errors++;
            $display("FAIL prio_clr inst%0d: q=%0d, required 0", s, q_o[s]);
         end
      end
      step(0, 0, 0, 1, 0, 1, 9);
      step(0, 1, 0, 1, 0, 1, 6);
      for (int s = 0; s < 2; s++) begin
         checks++;
         if (q_o[s] !== 8'd6) begin
            errors++;
            $display("FAIL prio_load inst%0d: q=%0d, required 6", s, q_o[s]);
         end
      end
      $display("test_priority done");
   endtask

   task automatic test_boundaries();
      step(0, 0, 0, 1, 0, 0, 4);
      step(0, 1, 1, 0, 0, 0, 4);   // subtract to exactly zero
      step(0, 1, 1, 0, 0, 0, 0);   // subtract zero from zero
      step(0, 1, 0, 0, 0, 0, 0);   // add zero
      for (int s = 0; s < 2; s++) begin
         checks++;
         if (q_o[s] !== 8'd0 || ovf_o[s][0] !== 1'b0) begin
            errors++;
            $display("FAIL bound_zero inst%0d: q=%0d ovf0=%0b, required q=0 ovf0=0", s, q_o[s], ovf_o[s][0]);
         end
      end
      $display("test_boundaries done");
   endtask

   task automatic test_reset_mid();
      step(0, 1, 0, 0, 0, 0, 9);
      step(1, 1, 0, 0, 0, 0, 4);
      for (int s = 0; s < 2; s++) begin
         checks++;
         if (q_o[s] !== 8'd0 || qv_o[s] !== 1'b0 || ovf_o[s] !== 4'b0000) begin
            errors++;
            $display("FAIL reset_mid inst%0d: q=%0d vld=%0b ovf=%b, required q=0 vld=0 ovf=0000",
                     s, q_o[s], qv_o[s], ovf_o[s]);
         end
      end
      step(0, 1, 0, 0, 0, 0, 0);
      for (int s = 0; s < 2; s++) begin
         checks++;
         if (q_o[s] !== 8'd0 || qv_o[s] !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_read inst%0d: q=%0d vld=%0b, required q=0 vld=1", s, q_o[s], qv_o[s]);
         end
      end
      $display("test_reset_mid done");
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         int  kind = $urandom_range(0, 99);
         bit  r    = (kind == 0);
         bit  cl   = ($urandom_range(0, 19) == 0);
         bit  ld   = ($urandom_range(0, 9) == 0);
         bit  e    = ($urandom_range(0, 9) < 7);
         bit  sb   = $urandom_range(0, 1);
         int  c    = $urandom_range(0, 3);
         int  dd   = $urandom_range(0, 15);
         step(r, e, sb, ld, cl, c, dd);
         for (int s = 0; s < 2; s++) begin
            checks++;
            if (q_o[s] !== 8'(m_q[s]) || qch_o[s] !== 2'(m_qch[s]) || qv_o[s] !== m_qv[s]
                || ovf_o[s] !== model_ovf(s)) begin
               errors++;
               $display("FAIL random step%0d inst%0d: q=%0d q_ch=%0d vld=%0b ovf=%b, required q=%0d q_ch=%0d vld=%0b ovf=%b",
                        i, s, q_o[s], qch_o[s], qv_o[s], ovf_o[s], m_q[s], m_qch[s], m_qv[s], model_ovf(s));
            end
         end
      end
      $display("test_random done");
   endtask

   initial begin
      for (int s = 0; s < 2; s++) begin
         for (int k = 0; k < 4; k++) begin m_acc[s][k] = 0; m_ovf[s][k] = 0; end
         m_q[s] = 0; m_qch[s] = 0; m_qv[s] = 0;
      end
      test_reset();
      test_independent();
      test_wrap();
      test_underflow();
      test_priority();
      test_boundaries();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
